// File: rtl/ser_frame_pkg.sv
// Shared frame-format definitions for the serial transmitter and receiver.
// Both ends import this package so the line levels and frame layout have one home.
package ser_frame_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      ADDR  = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4,
      GAP   = 3'd5
   } state_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam logic IDLE_LVL  = 1'b1;

   // Cycles on the line for one frame: start + address + data + stop.
   function automatic int frame_len(input int addrW, input int dataW);
      return 1 + addrW + dataW + 1;
   endfunction

   // Largest of three field lengths; sizes the shared down-counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/ser_frame_tx_if.sv
// Word-input handshake between a data source and the serial frame transmitter.
interface ser_frame_tx_if #(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4
);

   logic              inValid;
   logic              inReady;
   logic [ADDR_W-1:0] inAddr;
   logic [DATA_W-1:0] inData;

   modport master (
      output inValid,
      output inAddr,
      output inData,
      input  inReady
   );

   modport slave (
      input  inValid,
      input  inAddr,
      input  inData,
      output inReady
   );

endinterface

// File: rtl/ser_frame_tx_piso_shift.sv
// Parallel-load, MSB-first shift register feeding the serial line.
module piso_shift #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         msb
);

   logic [W-1:0] shReg;

   // Load wins over shift so a new word is never corrupted by a stray shift.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shReg <= '0;
      end else if (load) begin
         shReg <= din;
      end else if (shift) begin
         shReg <= {shReg[W-2:0], 1'b0};
      end
   end

   assign msb = shReg[W-1];

endmodule

// File: rtl/ser_frame_tx.sv
// Serial frame transmitter: captures one (address, data) word per handshake and
// sends start, address MSB-first, data MSB-first, stop, then an idle gap.
module ser_frame_tx
   import ser_frame_pkg::*;
#(
   parameter int ADDR_W = 2,
   parameter int DATA_W = 4,
   parameter int GAP    = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   ser_frame_tx_if.slave      bus,
   output logic               serOut,
   output logic               busy
);

   localparam int CNT_W = $clog2(max3(ADDR_W, DATA_W, GAP) + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             load;
   logic             shift;
   logic             nextBit;

   assign bus.inReady = (state == IDLE);
   assign busy        = (state != IDLE);
   assign load        = bus.inValid && bus.inReady;
   assign shift       = (state == START) || (state == ADDR) || (state == DATA);

   piso_shift #(
      .W (ADDR_W + DATA_W)
   ) uShift (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .shift (shift),
      .din   ({bus.inAddr, bus.inData}),
      .msb   (nextBit)
   );

   // Frame sequencer: serOut is registered, so each state's line level is
   // scheduled on the edge that enters it and the counter reloads on entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         serOut <= IDLE_LVL;
      end else begin
         case (state)
            IDLE: begin
               serOut <= IDLE_LVL;
               cnt    <= '0;
               if (bus.inValid) begin
                  state  <= START;
                  serOut <= START_BIT;
               end
            end
            START: begin
               state  <= ADDR;
               serOut <= nextBit;
               cnt    <= ADDR_LAST;
            end
            ADDR: begin
               serOut <= nextBit;
               if (cnt == '0) begin
                  state <= DATA;
                  cnt   <= DATA_LAST;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DATA: begin
               if (cnt == '0) begin
                  state  <= STOP;
                  serOut <= STOP_BIT;
                  cnt    <= '0;
               end else begin
                  serOut <= nextBit;
                  cnt    <= cnt - CNT_W'(1);
               end
            end
            STOP: begin
               serOut <= IDLE_LVL;
               if (GAP > 0) begin
                  state <= ser_frame_pkg::GAP;
                  cnt   <= GAP_LAST;
               end else begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end
            ser_frame_pkg::GAP: begin
               serOut <= IDLE_LVL;
               if (cnt == '0) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               serOut <= IDLE_LVL;
            end
         endcase
      end
   end

endmodule

// File: doc/ser_frame_tx.md
# ser_frame_tx

Serial frame transmitter that generates the `serIn` bit stream consumed by the serial receiver/demultiplexer stage. It accepts one (address, data) word per valid/ready handshake and serializes it MSB-first into a fixed frame: start bit, address field, data field, stop bit. It then holds the line idle for a programmable gap. The block sits directly upstream of the receiver, and its `serOut` connects to the receiver's serial input on the same clock.

## Interface
- `ADDR_W`, default 2: address field width; selects one of 2^ADDR_W receiver outputs (L0..L3).
- `DATA_W`, default 4: payload width; matches the receiver's 4-bit output registers.
- `GAP`, default 1: idle (`serOut`=1) cycles after each stop bit. Legal range 0..15.
- `CLK`  in  1  single clock; all state updates on the rising edge.
- `RST`  in  1  reset, asynchronous and active-low.
- `inValid`  in  1  `inAddr`/`inData` hold a word to send.
- `inReady`  out  1  block can accept a word this cycle.
- `inAddr`  in  ADDR_W  destination channel.
- `inData`  in  DATA_W  payload.
- `serOut`  out  1  serial line; idle level 1.
- `busy`  out  1  frame or gap in progress.

## Operation
- FSM states are IDLE, START, ADDR, DATA, STOP, GAP.
- IDLE: `inReady`=1, `serOut`=1, `busy`=0. When `inValid`&`inReady` at a rising edge, latch {`inAddr`,`inData`} into the shift register and go to START.
- START: `serOut`=0 for 1 cycle, then ADDR.
- ADDR: shift out `inAddr` MSB first, ADDR_W cycles, then DATA.
- DATA: shift out `inData` MSB first, DATA_W cycles, then STOP.
- STOP: `serOut`=1 for 1 cycle. Go to GAP if GAP>0, else IDLE.
- GAP: `serOut`=1 for GAP cycles, then IDLE.
- `inReady` is 1 only in IDLE, and is decoded combinationally from state. `busy` is 1 in every state except IDLE.
- A word is captured only on the handshake edge. Changes to `inAddr`/`inData` after that edge do not affect the frame in flight.
- `inValid` while not ready is ignored. The word is not lost: the source must hold it until `inReady`.
- Bit counter width is $clog2(max(ADDR_W,DATA_W,GAP)+1). It reloads on every state entry and counts down to the last bit.
- Reset (`RST`=0, asynchronous): state=IDLE, `serOut`=1, shift register=0, counter=0. `inReady` reads 1 and `busy` reads 0 as soon as `RST` deasserts.
- Reset mid-frame aborts the frame immediately. The line returns to 1 without a stop bit, and the receiver resynchronizes on the next start bit.

## Timing
- `serOut` is registered. The start bit appears in the cycle after the handshake edge.
- Frame length is 1+ADDR_W+DATA_W+1 = 8 cycles at defaults.
- Minimum handshake-to-handshake period is 1 (IDLE) + 8 + GAP = 10 cycles at defaults.
- `inValid` held high continuously produces back-to-back frames at exactly that period.
- The handshake edge and the first `serOut`=0 cycle are one clock apart. No other latency exists.
- GAP=0: IDLE follows STOP directly, so the line is 1 for exactly 2 cycles between frames (STOP + IDLE).
- `inValid` asserted in the same cycle that `RST` deasserts is accepted on the first rising edge with `RST`=1.

## Structure
- Package `ser_frame_pkg` holds:
  - the `state_t` enum (IDLE, START, ADDR, DATA, STOP, GAP);
  - constants `START_BIT`=1'b0, `STOP_BIT`=1'b1, `IDLE_LVL`=1'b1;
  - function `frame_len(ADDR_W,DATA_W)`.
- The receiver stage imports the same package, so the frame format has a single definition.
- Sub-module `piso_shift`: parallel-load, MSB-first shift register (width ADDR_W+DATA_W) with `load` and `shift` enables. The FSM and counter live in `ser_frame_tx`.

## Test plan
- Reset hold: `RST`=0 for 5 cycles with `inValid`=1 → `serOut`=1, `busy`=0, no frame starts. After release, `inReady`=1.
- Single frame: `inAddr`=2'b10, `inData`=4'b0110 → `serOut` = 0,1,0,0,1,1,0,1 over 8 cycles, then 1 for GAP cycles. `inReady`=0 throughout.
- Back-to-back with `inValid` held: words (2'b00,4'b1111) then (2'b11,4'b0001) → second start bit exactly 10 cycles after the first. Bit streams are 0,0,0,1,1,1,1,1 and 0,1,1,0,0,0,1,1.
- Input change mid-frame: toggle `inData` every cycle after the handshake of (2'b01,4'b1010) → frame is still 0,0,1,1,0,1,0,1.
- Reset mid-frame: assert `RST` during the DATA state → `serOut`=1 asynchronously, before the next edge. After release, a new word (2'b10,4'b0011) sends a clean frame.
- End-to-end: drive the receiver with `serOut` for words to addresses 0..3 with data 4'h3, 4'h5, 4'h9, 4'hC → receiver L0=3, L1=5, L2=9, L3=C.
